// File: rtl/mic_control.sv
// mic_control: I2S master-mode receiver for the stereo ADC.
//
// Derives the ADC master clock (clk/4), serial clock (clk/8) and word
// select (clk/512) from one free-running 9-bit counter. It deserialises
// MSB-first left/right samples and hands each completed stereo pair to
// the consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst          crystal clock, synchronous active-high reset
//   en                capture enable (the clocks run regardless)
//   audio_sdout       serial data from the ADC (asynchronous)
//   audio_mclk        master clock  = clk_cnt[1]
//   audio_lrck        word select   = clk_cnt[8] (0 = left, 1 = right)
//   audio_sck         serial clock  = clk_cnt[2]
//   audio_out_left    last complete left sample (two's complement)
//   audio_out_right   last complete right sample
//   audio_out_mono    (left + right) >>> 1, only with MIC_MONO_MIX_EN
//   out_valid         pair available
//   out_ready         consumer accepts pair
//   overrun           sticky: a pair was overwritten before acceptance
//
// Optional feature macro: MIC_MONO_MIX_EN adds the audio_out_mono output.

module mic_control #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              audio_sdout,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    output logic [DATA_W-1:0] audio_out_left,
    output logic [DATA_W-1:0] audio_out_right,
`ifdef MIC_MONO_MIX_EN
    output logic [DATA_W-1:0] audio_out_mono,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    localparam logic [4:0] LAST_SLOT = 5'(DATA_W);

    logic [8:0]        clk_cnt_q, clk_cnt_d;
    logic              sd_meta_q, sd_meta_d;
    logic              sd_sync_q, sd_sync_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_l_q, shift_l_d;
    logic [DATA_W-1:0] shift_r_q, shift_r_d;
    logic [DATA_W-1:0] out_left_q, out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;

    logic [4:0]        slot;
    logic              bit_take;
    logic              frame_end;
    logic              frame_done;
    logic              xfer;

`ifdef MIC_MONO_MIX_EN
    logic [DATA_W-1:0] out_mono_q, out_mono_d;
    logic [DATA_W:0]   mono_sum;
`endif

    always_comb begin
        slot      = clk_cnt_q[7:3];
        frame_end = (clk_cnt_q == 9'd511);
        // Slot 0 is the I2S one-bit delay; slots past DATA_W are don't-care.
        bit_take  = (clk_cnt_q[2:0] == 3'd6) && (slot != 5'd0) && (slot <= LAST_SLOT);
        xfer      = out_valid_q && out_ready;

        clk_cnt_d  = clk_cnt_q + 9'd1;
        sd_meta_d  = audio_sdout;
        sd_sync_d  = sd_meta_q;
        state_d    = state_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        frame_done = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (frame_end && en) begin
                    state_d = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (bit_take) begin
                    shift_l_d = {shift_l_q[DATA_W-2:0], sd_sync_q};
                end
                if (!en) begin
                    state_d = ST_SYNC;
                end else if (clk_cnt_q == 9'd255) begin
                    state_d = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (bit_take) begin
                    shift_r_d = {shift_r_q[DATA_W-2:0], sd_sync_q};
                end
                // The frame end publishes the pair even if en falls on
                // that same cycle; only then does en pick the next state.
                if (frame_end) begin
                    frame_done = 1'b1;
                    state_d    = en ? ST_LEFT : ST_SYNC;
                end else if (!en) begin
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (frame_done) begin
            out_left_d  = shift_l_q;
            out_right_d = shift_r_q;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MIC_MONO_MIX_EN
    always_comb begin
        // One extra bit of headroom, so the sum cannot overflow.
        mono_sum   = {shift_l_q[DATA_W-1], shift_l_q} + {shift_r_q[DATA_W-1], shift_r_q};
        out_mono_d = frame_done ? DATA_W'(mono_sum >> 1) : out_mono_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_mono_q <= '0;
        end else begin
            out_mono_q <= out_mono_d;
        end
    end

    assign audio_out_mono = out_mono_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q   <= '0;
            sd_meta_q   <= 1'b0;
            sd_sync_q   <= 1'b0;
            state_q     <= ST_SYNC;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            clk_cnt_q   <= clk_cnt_d;
            sd_meta_q   <= sd_meta_d;
            sd_sync_q   <= sd_sync_d;
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign audio_mclk      = clk_cnt_q[1];
    assign audio_sck       = clk_cnt_q[2];
    assign audio_lrck      = clk_cnt_q[8];
    assign audio_out_left  = out_left_q;
    assign audio_out_right = out_right_q;
    assign out_valid       = out_valid_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_mic_control.sv
// tb_mic_control: self-checking bench for mic_control.
// An ADC model drives I2S frames; a frame-level reference model predicts
// the pair, handshake and overrun behaviour and is compared every cycle.

module tb_mic_control;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              audio_sdout = 1'b0;
    logic              out_ready = 1'b0;
    logic              audio_mclk, audio_lrck, audio_sck;
    logic [DATA_W-1:0] audio_out_left, audio_out_right;
    logic              out_valid, overrun;
`ifdef MIC_MONO_MIX_EN
    logic [DATA_W-1:0] audio_out_mono;
`endif

    mic_control #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .audio_sdout     (audio_sdout),
        .audio_mclk      (audio_mclk),
        .audio_lrck      (audio_lrck),
        .audio_sck       (audio_sck),
        .audio_out_left  (audio_out_left),
        .audio_out_right (audio_out_right),
`ifdef MIC_MONO_MIX_EN
        .audio_out_mono  (audio_out_mono),
`endif
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned       m_cnt = 0;   // position within the 512-clk frame
    int unsigned       m_run = 0;   // consecutive clks with en high
    logic              m_valid = 1'b0;
    logic              m_over = 1'b0;
    logic [DATA_W-1:0] m_l = '0, m_r = '0, m_mono = '0;
    logic [DATA_W-1:0] cur_l = '0, cur_r = '0;   // sample the ADC sends this frame
    logic [DATA_W-1:0] fix_l = '0, fix_r = '0;
    bit                use_fixed = 1'b1;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int vpulses = 0;
    int last_sck_rise = -1, sck_period = 0;
    int last_lrck_rise = -1, lrck_period = 0;
    logic prev_sck = 1'b0, prev_lrck = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic new_frame();
        if (use_fixed) begin
            cur_l = fix_l;
            cur_r = fix_r;
        end else begin
            cur_l = DATA_W'($urandom);
            cur_r = DATA_W'($urandom);
        end
    endtask

    // Bit the ADC presents for the slot containing frame position c.
    function automatic logic sd_bit(input int unsigned c);
        logic [8:0]        c9;
        int unsigned       s;
        logic [DATA_W-1:0] smp;
        c9  = c[8:0];
        s   = int'(c9[7:3]);
        smp = c9[8] ? cur_r : cur_l;
        if (s >= 1 && s <= DATA_W) return smp[DATA_W - s];
        return 1'($urandom);
    endfunction

    task automatic step();
        bit done;
        int sum;
        logic [8:0] c9;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_cnt = 0; m_run = 0; m_valid = 0; m_over = 0;
            m_l = '0; m_r = '0; m_mono = '0;
        end else begin
            // A pair completes when en was high for a whole frame plus the
            // boundary clk before it.
            done = (m_cnt == 511) && (m_run >= 512);
            if (done) begin
                if (m_valid && !out_ready) m_over = 1'b1;
                m_valid = 1'b1;
                m_l = cur_l;
                m_r = cur_r;
                sum = $signed(cur_l) + $signed(cur_r);
                m_mono = DATA_W'(sum >>> 1);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            m_run = en ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            m_cnt = (m_cnt + 1) % 512;
        end
        if (m_cnt == 0) new_frame();
        #1;
        c9 = m_cnt[8:0];
        chk("out_valid", out_valid, m_valid);
        chk("overrun", overrun, m_over);
        chk("left", audio_out_left, m_l);
        chk("right", audio_out_right, m_r);
        chk("mclk", audio_mclk, c9[1]);
        chk("sck", audio_sck, c9[2]);
        chk("lrck", audio_lrck, c9[8]);
`ifdef MIC_MONO_MIX_EN
        chk("mono", audio_out_mono, m_mono);
`endif
        if (out_valid === 1'b1) vpulses++;
        if (audio_sck === 1'b1 && !prev_sck) begin
            if (last_sck_rise >= 0) sck_period = cyc - last_sck_rise;
            last_sck_rise = cyc;
        end
        if (audio_lrck === 1'b1 && !prev_lrck) begin
            if (last_lrck_rise >= 0) lrck_period = cyc - last_lrck_rise;
            last_lrck_rise = cyc;
        end
        prev_sck = audio_sck;
        prev_lrck = audio_lrck;
        audio_sdout = sd_bit(m_cnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int off;
        bit found;

        // Reset state, then first pair timing with fixed samples
        use_fixed = 1; fix_l = 16'h8001; fix_r = 16'h7FFE;
        rst = 1; en = 0; out_ready = 1;
        repeat (3) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_left", audio_out_left, 0);
        chk("rst_lrck", audio_lrck, 0);
        rst = 0; en = 1;
        repeat (1023) step();
        chk("first_pair_not_early", out_valid, 0);
        step();
        chk("first_pair_valid", out_valid, 1);
        chk("first_left", audio_out_left, 16'h8001);
        chk("first_right", audio_out_right, 16'h7FFE);
        chk("sck_period", sck_period, 8);
        chk("lrck_period", lrck_period, 512);

        // Continuous capture with ready tied high
        fix_l = 16'h1234; fix_r = 16'hABCD;
        repeat (512) step();
        vpulses = 0;
        repeat (2048) step();
        chk("pulses_in_4_frames", vpulses, 4);
        chk("last_left", audio_out_left, 16'h1234);
        chk("last_right", audio_out_right, 16'hABCD);
        chk("overrun_clear", overrun, 0);

        // Consumer stalls across two frames
        use_fixed = 0; out_ready = 0;
        repeat (511) step();
        chk("held_valid", out_valid, 1);
        chk("held_left", audio_out_left, 16'h1234);
        chk("no_overrun_yet", overrun, 0);
        step();
        chk("overrun_set", overrun, 1);
        repeat (50) step();
        out_ready = 1;
        step();
        chk("valid_cleared", out_valid, 0);
        chk("overrun_sticky", overrun, 1);

        // Abort a frame by dropping en at position 100 of a left half
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (m_cnt == 100) found = 1;
        end
        chk("reach_cnt100", found, 1);
        en = 0;
        vpulses = 0;
        repeat (200) step();
        en = 1;
        repeat (723) step();
        chk("no_pair_after_abort", vpulses, 0);
        step();
        chk("pair_after_resync", out_valid, 1);

        // Randomised traffic: ready toggling, occasional en drops
        off = 0;
        for (int i = 0; i < 6000; i++) begin
            out_ready = 1'($urandom);
            if (off > 0) begin
                off--;
                if (off == 0) en = 1;
            end else if ($urandom_range(0, 399) == 0) begin
                en = 0;
                off = $urandom_range(1, 600);
            end
            step();
        end

        // Reset mid-frame while a pair is pending
        en = 1; out_ready = 0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (out_valid === 1'b1 && m_cnt == 300) found = 1;
        end
        chk("reach_valid_cnt300", found, 1);
        rst = 1;
        step();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_left", audio_out_left, 0);
        chk("midrst_right", audio_out_right, 0);
        chk("midrst_clocks", {audio_mclk, audio_sck, audio_lrck}, 0);

        // Mono-mix corner values (checked only when the port exists)
        use_fixed = 1; fix_l = 16'h7FFF; fix_r = 16'h7FFF;
        out_ready = 1;
        rst = 0;
        repeat (1024) step();
        chk("mix_pair1_valid", out_valid, 1);
`ifdef MIC_MONO_MIX_EN
        chk("mono_7fff", audio_out_mono, 16'h7FFF);
`endif
        fix_l = 16'h8000; fix_r = 16'h0000;
        repeat (1024) step();
        chk("mix_pair2_left", audio_out_left, 16'h8000);
`ifdef MIC_MONO_MIX_EN
        chk("mono_c000", audio_out_mono, 16'hC000);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mic_control.md
Name: mic_control

Overview:
- I2S receiver (master mode) for the stereo ADC side of the audio codec; the counterpart of the DAC speaker transmitter.
- Generates the ADC master, word-select and serial clocks from the crystal clock.
- Deserialises left and right samples and presents each completed stereo pair to the DSP/recording logic over a valid/ready handshake.

Parameters:
DATA_W, 16, captured bits per channel, MSB-first; legal range 8..24; bits beyond DATA_W in each channel are ignored.

Ports:
clk  input  1  clock from the crystal (100 MHz)
rst  input  1  synchronous, active-high reset
en  input  1  capture enable; clocks run regardless
audio_sdout  input  1  serial data from ADC
audio_mclk  output  1  master clock = clk_cnt[1] (clk/4)
audio_lrck  output  1  word select = clk_cnt[8] (clk/512); 0 = left, 1 = right
audio_sck  output  1  serial clock = clk_cnt[2] (clk/8, 64 sck per frame)
audio_out_left  output  DATA_W  last complete left sample, two's complement
audio_out_right  output  DATA_W  last complete right sample
out_valid  output  1  pair available
out_ready  input  1  consumer accepts pair
overrun  output  1  sticky: a pair was overwritten before it was accepted

Behaviour:
- clk_cnt: 9-bit free-running counter; 0 on rst, +1 every clk; wraps 511 -> 0. Frame boundary = clk_cnt==511.
- Input path:
  - audio_sdout passes a 2-flop synchroniser (both flops reset to 0).
  - Bit-capture strobe = clk_cnt[2:0]==3'd6.
  - Slot = clk_cnt[7:3] (0..31); channel = clk_cnt[8].
- I2S framing:
  - Slot 0 of each channel is the one-bit delay slot and is discarded.
  - Slots 1..DATA_W carry MSB..LSB; the synchronised bit is shifted into that channel's shift register on the strobe.
  - Slots above DATA_W are ignored.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC: shift registers ignored. Go to LEFT at a frame boundary when en=1.
  - LEFT (lrck=0): capture left bits. Go to RIGHT when clk_cnt==255.
  - RIGHT (lrck=1): capture right bits. At clk_cnt==511:
    - both shift registers are copied to audio_out_left/right;
    - out_valid is set;
    - stay in RIGHT->LEFT (next frame) if en=1, else go to SYNC.
  - en=0 in LEFT or RIGHT: go to SYNC on the next clk; the partial frame is discarded and the outputs are unchanged.
- Latency: the pair appears on the clk edge following clk_cnt==511, i.e. with out_valid=1 while clk_cnt==0.
- Handshake:
  - Transfer occurs on a clk edge with out_valid=1 and out_ready=1; out_valid then clears.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - A frame completes in the same cycle as a transfer: new data loads, out_valid stays 1, overrun is not set.
  - A frame completes with out_valid=1 and no transfer: new data overwrites, out_valid stays 1, overrun is set.
- overrun clears only on rst.
- Reset values: clk_cnt=0, state=SYNC, audio_out_left/right=0, out_valid=0, overrun=0, audio_mclk/lrck/sck=0.
- Reset mid-frame: everything returns to the reset values on the next clk. The first usable frame starts at clk_cnt==0 after SYNC, so the first pair arrives at the earliest 1024 clk after rst is released (one full frame of SYNC, then one captured frame).

Optional Feature:
MIC_MONO_MIX_EN
- Defined: adds output audio_out_mono [DATA_W-1:0] = (signed left + signed right) >>> 1.
  - Computed at DATA_W+1 bits; no overflow.
  - Registered together with the pair; reset value 0.
  - Covered by the same out_valid.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset release, en=1, ADC model sends L=16'h8001, R=16'h7FFE each frame -> out_valid first at 1024 clk after rst release (clk_cnt==0); outputs match exactly; audio_sck period 8 clk, audio_lrck period 512 clk.
- out_ready tied 1, 4 frames L=16'h1234, R=16'hABCD -> one out_valid pulse per 512 clk, each 1 clk wide; overrun stays 0.
- out_ready held 0 across two frames -> first pair held stable until overwrite; overrun=1 at the second frame completion; raising out_ready clears out_valid but not overrun.
- en dropped at clk_cnt==100 of a LEFT half -> no pair from that frame; out_valid stays 0; en re-raised -> next pair after a full SYNC+capture sequence.
- rst asserted at clk_cnt==300 with out_valid=1 -> next clk: all outputs 0 and clk_cnt=0.
- MIC_MONO_MIX_EN defined, L=16'h7FFF, R=16'h7FFF -> mono=16'h7FFF; L=16'h8000, R=16'h0000 -> mono=16'hC000.
